tlb_refill_ctrl: RTL and testbench
==================================

Name: tlb_refill_ctrl

Overview:
- Front-end controller for the shared TLB: arbitrates two lookup requesters (port 0 instruction side, port 1 data side) onto the single TLB lookup path.
- On a miss, sequences a page walk, drives the TLB insert/pa lines, replays the lookup and returns the translation.
- Also owns TLB flush (drives the TLB shutdown line).
- Sits between the fetch/LSU front ends and the cache/pmu pair; the pmu observes the same hit/miss/insert strobes it drives.

Parameters:
- VA_W, 64, virtual/physical address width.
- PCID_W, 12, process-context id width.
- INSERT_CYCLES, 2, cycles insert is held high during refill (>=1).
- WALK_TIMEOUT, 255, max cycles waiting for walk response before fault (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- shutdown_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port lookup request valid (bit0 = port 0)
- req_ready  out  2  per-port request accepted this cycle
- req_va  in  2*VA_W  per-port virtual address, port 0 in LSBs
- req_pcid  in  2*PCID_W  per-port pcid
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  port the response belongs to
- rsp_pa  out  VA_W  translated address
- rsp_fault  out  1  walk faulted or timed out; rsp_pa = 0
- flush_req  in  1  request full TLB flush (level)
- flush_done  out  1  one-cycle pulse when flush issued
- tlb_va  out  VA_W  TLB lookup/insert va
- tlb_pcid  out  PCID_W  TLB pcid
- tlb_pa  out  VA_W  TLB insert pa
- tlb_insert  out  1  TLB insert
- tlb_shutdown  out  1  TLB flush pulse
- tlb_addr  in  VA_W  TLB output address
- tlb_hit  in  1  TLB hit
- tlb_miss  in  1  TLB miss
- walk_req  out  1  page-walk request valid
- walk_ack  in  1  walker accepted request
- walk_va  out  VA_W  va to walk (registered)
- walk_pcid  out  PCID_W  pcid to walk
- walk_rsp_valid  in  1  walk result valid
- walk_pa  in  VA_W  walked physical address
- walk_fault  in  1  walk fault

Behaviour:
- Reset (async, shutdown_n=0): state IDLE; all outputs 0; round-robin pointer = port 0; timeout counter 0. Reset mid-walk abandons transaction: no response, walk_req drops immediately; late walk_rsp_valid in IDLE is ignored.
- One transaction in flight. req_ready asserted only in IDLE, only for the granted port; request captured (va, pcid, id) same edge.
- Arbitration: both valid -> grant port indicated by RR pointer; pointer flips to other port after each grant. Single valid -> grant it, pointer moves past it.
- Priority in IDLE: flush_req beats new requests.
- States:
  - IDLE: flush_req -> FLUSH; else grant -> LOOKUP.
  - LOOKUP: tlb_va/tlb_pcid driven from captured request (held through REPLAY). TLB result sampled next cycle. tlb_hit -> RESP with pa=tlb_addr; tlb_miss -> WALK_REQ; neither -> wait.
  - WALK_REQ: walk_req=1 with walk_va/walk_pcid until walk_ack sampled high -> WALK_WAIT.
  - WALK_WAIT: counter increments each cycle. walk_rsp_valid & !walk_fault -> capture walk_pa -> INSERT. walk_rsp_valid & walk_fault -> RESP fault. Counter reaches WALK_TIMEOUT -> RESP fault. Response on the timeout cycle wins over timeout.
  - INSERT: tlb_insert=1 and tlb_pa=walked pa for exactly INSERT_CYCLES cycles -> REPLAY.
  - REPLAY: as LOOKUP. Hit -> RESP with tlb_addr. Miss -> RESP with captured walk pa (no second walk).
  - RESP: rsp_valid=1 one cycle with rsp_id/rsp_pa/rsp_fault -> IDLE. rsp_pa/rsp_fault are 0 whenever rsp_valid=0.
  - FLUSH: tlb_shutdown=1 one cycle, flush_done=1 same cycle -> IDLE. flush_req during a transaction waits until IDLE.
- Latency: hit path = grant + 2 cycles to rsp_valid. Miss path = 4 + INSERT_CYCLES + walk latency.
- Counter width = clog2(WALK_TIMEOUT+1); clears on entry to WALK_WAIT.

Test Plan:
- Reset, then port 0 va=64'hfffffffffffffff1 pcid=0, TLB hits with tlb_addr=64'h1000 -> rsp_valid exactly 2 cycles after grant, rsp_id=0, rsp_pa=64'h1000, no walk_req.
- Port 1 same va with pcid=1, TLB misses; walker acks after 3 cycles and returns pa=64'h2000 -> tlb_insert high exactly INSERT_CYCLES cycles with tlb_pa=64'h2000; replay hits; rsp_id=1, rsp_pa=64'h2000.
- Both ports valid every cycle for 4 grants -> grants alternate 0,1,0,1; each request receives exactly one response.
- Walker never responds -> rsp_fault=1, rsp_pa=0 after WALK_TIMEOUT cycles in WALK_WAIT; walk_fault=1 case also gives rsp_fault=1 with no tlb_insert.
- flush_req raised during WALK_WAIT -> tlb_shutdown pulses only after rsp_valid, on the cycle after return to IDLE; flush_req and req_valid together in IDLE -> flush first.
- shutdown_n dropped mid-INSERT -> outputs 0 asynchronously; a stale walk_rsp_valid after release produces no response.

Source files
------------

// File: rtl/tlb_refill_ctrl.sv
// TLB front-end controller: arbitrates two lookup ports onto one TLB path,
// sequences page walk, insert and replay on a miss, and issues full TLB flushes.
module tlb_refill_ctrl #(
  parameter int VA_W          = 64,
  parameter int PCID_W        = 12,
  parameter int INSERT_CYCLES = 2,
  parameter int WALK_TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                shutdown_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*VA_W-1:0]   req_va,
  input  logic [2*PCID_W-1:0] req_pcid,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [VA_W-1:0]     rsp_pa,
  output logic                rsp_fault,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [VA_W-1:0]     tlb_va,
  output logic [PCID_W-1:0]   tlb_pcid,
  output logic [VA_W-1:0]     tlb_pa,
  output logic                tlb_insert,
  output logic                tlb_shutdown,
  input  logic [VA_W-1:0]     tlb_addr,
  input  logic                tlb_hit,
  input  logic                tlb_miss,
  output logic                walk_req,
  input  logic                walk_ack,
  output logic [VA_W-1:0]     walk_va,
  output logic [PCID_W-1:0]   walk_pcid,
  input  logic                walk_rsp_valid,
  input  logic [VA_W-1:0]     walk_pa,
  input  logic                walk_fault
);

  localparam int CNT_W = $clog2(WALK_TIMEOUT + 1);
  localparam int INS_W = $clog2(INSERT_CYCLES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WALK_REQ  = 3'd2;
  localparam logic [2:0] S_WALK_WAIT = 3'd3;
  localparam logic [2:0] S_INSERT    = 3'd4;
  localparam logic [2:0] S_REPLAY    = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;
  localparam logic [2:0] S_FLUSH     = 3'd7;

  logic [2:0]        r_state;
  logic              r_rr;
  logic              r_id;
  logic [VA_W-1:0]   r_va;
  logic [PCID_W-1:0] r_pcid;
  logic [VA_W-1:0]   r_walk_pa;
  logic [VA_W-1:0]   r_rsp_pa;
  logic              r_rsp_fault;
  logic [CNT_W-1:0]  r_cnt;
  logic [INS_W-1:0]  r_ins_cnt;

  logic              w_grant;
  logic              w_gid;
  logic              w_busy_tlb;

  // Flush outranks new requests; the round-robin pointer only matters on a tie.
  assign w_grant = (r_state == S_IDLE) && !flush_req && (|req_valid);
  assign w_gid   = (req_valid == 2'b11) ? r_rr : req_valid[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    req_ready = 2'b00;
    if (w_grant && shutdown_n) begin
      req_ready[w_gid] = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge shutdown_n) begin
    if (!shutdown_n) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_id        <= 1'b0;
      r_va        <= '0;
      r_pcid      <= '0;
      r_walk_pa   <= '0;
      r_rsp_pa    <= '0;
      r_rsp_fault <= 1'b0;
      r_cnt       <= '0;
      r_ins_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state <= S_FLUSH;
          end else if (w_grant) begin
            r_id    <= w_gid;
            r_va    <= w_gid ? req_va[2*VA_W-1:VA_W] : req_va[VA_W-1:0];
            r_pcid  <= w_gid ? req_pcid[2*PCID_W-1:PCID_W] : req_pcid[PCID_W-1:0];
            r_rr    <= ~w_gid;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (tlb_hit) begin
            r_rsp_pa    <= tlb_addr;
            r_rsp_fault <= 1'b0;
            r_state     <= S_RESP;
          end else if (tlb_miss) begin
            r_state <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (walk_ack) begin
            r_cnt   <= '0;
            r_state <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          // A response arriving on the last allowed cycle still beats the timeout.
          if (walk_rsp_valid && !walk_fault) begin
            r_walk_pa <= walk_pa;
            r_ins_cnt <= '0;
            r_state   <= S_INSERT;
          end else if (walk_rsp_valid || (r_cnt == CNT_W'(WALK_TIMEOUT - 1))) begin
            r_rsp_pa    <= '0;
            r_rsp_fault <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_INSERT: begin
          if (r_ins_cnt == INS_W'(INSERT_CYCLES - 1)) begin
            r_state <= S_REPLAY;
          end else begin
            r_ins_cnt <= r_ins_cnt + INS_W'(1);
          end
        end
        S_REPLAY: begin
          // A replay miss falls back to the walked address rather than walking again.
          if (tlb_hit || tlb_miss) begin
            r_rsp_pa    <= tlb_hit ? tlb_addr : r_walk_pa;
            r_rsp_fault <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy_tlb   = (r_state >= S_LOOKUP) && (r_state <= S_REPLAY);

  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_id       = rsp_valid ? r_id : 1'b0;
  assign rsp_pa       = rsp_valid ? r_rsp_pa : '0;
  assign rsp_fault    = rsp_valid ? r_rsp_fault : 1'b0;

  assign tlb_va       = w_busy_tlb ? r_va : '0;
  assign tlb_pcid     = w_busy_tlb ? r_pcid : '0;
  assign tlb_insert   = (r_state == S_INSERT);
  assign tlb_pa       = tlb_insert ? r_walk_pa : '0;

  assign tlb_shutdown = (r_state == S_FLUSH);
  assign flush_done   = (r_state == S_FLUSH);

  assign walk_req     = (r_state == S_WALK_REQ);
  assign walk_va      = walk_req ? r_va : '0;
  assign walk_pcid    = walk_req ? r_pcid : '0;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Scoreboard bench for tlb_refill_ctrl with a small TLB model and a
// configurable page walker; expectations are queued at grant, checked at response.
module tb_tlb_refill_ctrl;

  localparam int VA_W   = 64;
  localparam int PCID_W = 12;
  localparam int IC     = 3;
  localparam int TO     = 16;
  localparam int NT     = 16;

  logic                clk = 1'b0;
  logic                shutdown_n;
  logic [1:0]          req_valid, req_ready;
  logic [2*VA_W-1:0]   req_va;
  logic [2*PCID_W-1:0] req_pcid;
  logic                rsp_valid, rsp_id, rsp_fault;
  logic [VA_W-1:0]     rsp_pa;
  logic                flush_req, flush_done;
  logic [VA_W-1:0]     tlb_va, tlb_pa, tlb_addr;
  logic [PCID_W-1:0]   tlb_pcid;
  logic                tlb_insert, tlb_shutdown, tlb_hit, tlb_miss;
  logic                walk_req, walk_ack, walk_rsp_valid, walk_fault;
  logic [VA_W-1:0]     walk_va, walk_pa;
  logic [PCID_W-1:0]   walk_pcid;

  always #5 clk = ~clk;

  tlb_refill_ctrl #(
    .VA_W(VA_W), .PCID_W(PCID_W), .INSERT_CYCLES(IC), .WALK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .shutdown_n(shutdown_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .flush_req(flush_req), .flush_done(flush_done),
    .tlb_va(tlb_va), .tlb_pcid(tlb_pcid), .tlb_pa(tlb_pa), .tlb_insert(tlb_insert),
    .tlb_shutdown(tlb_shutdown), .tlb_addr(tlb_addr), .tlb_hit(tlb_hit), .tlb_miss(tlb_miss),
    .walk_req(walk_req), .walk_ack(walk_ack), .walk_va(walk_va), .walk_pcid(walk_pcid),
    .walk_rsp_valid(walk_rsp_valid), .walk_pa(walk_pa), .walk_fault(walk_fault)
  );

  logic any_out;
  assign any_out = |{req_ready, rsp_valid, rsp_id, rsp_pa, rsp_fault, flush_done, tlb_va,
                     tlb_pcid, tlb_pa, tlb_insert, tlb_shutdown, walk_req, walk_va, walk_pcid};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TLB model: fully associative table, filled by preload and by observed inserts.
  logic              tv[NT];
  logic [VA_W-1:0]   tva[NT];
  logic [VA_W-1:0]   tpa[NT];
  logic [PCID_W-1:0] tpc[NT];
  int                t_fill = 0;
  logic              tlb_quiet;

  task automatic tlb_add(input logic [VA_W-1:0] va, input logic [PCID_W-1:0] pc,
                         input logic [VA_W-1:0] pa);
    bit found;
    found = 0;
    for (int i = 0; i < NT; i++) begin
      if (tv[i] && tva[i] == va && tpc[i] == pc) begin
        tpa[i] = pa;
        found  = 1;
      end
    end
    if (!found && t_fill < NT) begin
      tv[t_fill]  = 1'b1;
      tva[t_fill] = va;
      tpc[t_fill] = pc;
      tpa[t_fill] = pa;
      t_fill++;
    end
  endtask

  always_comb begin
    tlb_hit  = 1'b0;
    tlb_miss = 1'b0;
    tlb_addr = '0;
    if (!tlb_quiet) begin
      tlb_miss = 1'b1;
      for (int i = 0; i < NT; i++) begin
        if (tv[i] && tva[i] == tlb_va && tpc[i] == tlb_pcid) begin
          tlb_hit  = 1'b1;
          tlb_miss = 1'b0;
          tlb_addr = tpa[i];
        end
      end
    end
  end

  // Page walker model.
  typedef enum logic [1:0] {WK_OK, WK_FAULT, WK_NORESP} wk_mode_e;
  wk_mode_e        wk_mode;
  int              wk_ack_dly, wk_rsp_dly;
  logic [VA_W-1:0] wk_pa_cfg;
  logic            wk_ack, wk_rsp, wk_flt;
  logic [VA_W-1:0] wk_pa;
  logic            t_rsp;
  logic [VA_W-1:0] t_pa;

  assign walk_ack       = wk_ack;
  assign walk_rsp_valid = wk_rsp | t_rsp;
  assign walk_pa        = wk_pa | t_pa;
  assign walk_fault     = wk_flt;

  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    wk_ack = 1'b0; wk_rsp = 1'b0; wk_flt = 1'b0; wk_pa = '0;
    forever begin
      @(posedge clk); #1;
      wk_ack = 1'b0; wk_rsp = 1'b0; wk_flt = 1'b0; wk_pa = '0;
      if (!shutdown_n) ph = 0;
      else begin
        case (ph)
          0: if (walk_req) begin
               if (wk_ack_dly == 0) begin wk_ack = 1'b1; ph = 2; cnt = 0; end
               else begin ph = 1; cnt = 1; end
             end
          1: if (cnt >= wk_ack_dly) begin wk_ack = 1'b1; ph = 2; cnt = 0; end
             else cnt++;
          2: if (wk_mode == WK_NORESP) ph = 0;
             else if (cnt >= wk_rsp_dly) begin
               wk_rsp = 1'b1;
               wk_flt = (wk_mode == WK_FAULT);
               wk_pa  = (wk_mode == WK_FAULT) ? '0 : wk_pa_cfg;
               ph = 0;
             end else cnt++;
          default: ph = 0;
        endcase
      end
    end
  end

  // Scoreboard and monitors, sampled on the falling edge.
  typedef struct packed {
    logic            id;
    logic [VA_W-1:0] pa;
    logic            fault;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   cyc = 0, n_grants = 0, n_rsp = 0, n_ins = 0, n_walk_req = 0, n_flush = 0, n_ack = 0;
  int   grant_cyc = 0, rsp_cyc = 0, ack_cyc = 0, shut_cyc = 0;
  logic [VA_W-1:0] ins_pa_last = '0;

  function automatic exp_t predict(input logic p, input logic [VA_W-1:0] va,
                                   input logic [PCID_W-1:0] pc);
    exp_t e;
    e.id = p; e.pa = '0; e.fault = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (tv[i] && tva[i] == va && tpc[i] == pc) begin
        e.pa = tpa[i];
        return e;
      end
    end
    if (wk_mode != WK_OK || wk_rsp_dly >= TO) e.fault = 1'b1;
    else e.pa = wk_pa_cfg;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!shutdown_n) begin
      sb_q.delete();
    end else begin
      if (req_ready[0] && req_valid[0]) begin
        sb_q.push_back(predict(1'b0, req_va[VA_W-1:0], req_pcid[PCID_W-1:0]));
        grant_log.push_back(0); n_grants++; grant_cyc = cyc;
      end
      if (req_ready[1] && req_valid[1]) begin
        sb_q.push_back(predict(1'b1, req_va[2*VA_W-1:VA_W], req_pcid[2*PCID_W-1:PCID_W]));
        grant_log.push_back(1); n_grants++; grant_cyc = cyc;
      end
      if (rsp_valid) begin
        n_rsp++; rsp_cyc = cyc;
        check("rsp_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_pa", rsp_pa, e.pa);
          check("rsp_fault", rsp_fault, e.fault);
        end
      end else begin
        check("rsp_idle_zero", {rsp_fault, rsp_pa}, 0);
      end
      if (tlb_insert) begin
        n_ins++; ins_pa_last = tlb_pa;
        tlb_add(tlb_va, tlb_pcid, tlb_pa);
      end
      if (walk_req) n_walk_req++;
      if (walk_req && walk_ack) begin n_ack++; ack_cyc = cyc; end
      if (tlb_shutdown || flush_done) begin
        n_flush++; shut_cyc = cyc;
        check("flush_done_pair", flush_done, tlb_shutdown);
      end
    end
  end

  task automatic issue(input int p, input logic [VA_W-1:0] va, input logic [PCID_W-1:0] pc);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (p == 1) begin
      req_va[2*VA_W-1:VA_W] = va; req_pcid[2*PCID_W-1:PCID_W] = pc;
    end else begin
      req_va[VA_W-1:0] = va; req_pcid[PCID_W-1:0] = pc;
    end
    req_valid[p] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    check("grant_seen", got, 1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int k = 0; k < budget && n_rsp < target; k++) @(posedge clk);
    check("rsp_arrived", n_rsp >= target, 1);
  endtask

  initial begin
    int r0, i0, w0, f0, g0, gs;
    bit seen;
    shutdown_n = 1'b0; req_valid = '0; req_va = '0; req_pcid = '0; flush_req = 1'b0;
    tlb_quiet = 1'b0; t_rsp = 1'b0; t_pa = '0;
    wk_mode = WK_OK; wk_ack_dly = 0; wk_rsp_dly = 0; wk_pa_cfg = '0;
    for (int i = 0; i < NT; i++) begin
      tv[i] = 1'b0; tva[i] = '0; tpa[i] = '0; tpc[i] = '0;
    end

    #12 check("reset_outs", any_out, 0);
    repeat (2) @(posedge clk);
    #1 shutdown_n = 1'b1;
    @(negedge clk) check("idle_no_ready", req_ready, 0);

    // Hit on port 0: response two cycles after grant, no walk.
    tlb_add(64'hffff_ffff_ffff_fff1, 12'd0, 64'h1000);
    w0 = n_walk_req;
    issue(0, 64'hffff_ffff_ffff_fff1, 12'd0);
    wait_rsp(1, 20);
    check("hit_latency", rsp_cyc - grant_cyc, 2);
    check("hit_no_walk", n_walk_req - w0, 0);

    // Miss on port 1: ack after 3 cycles, walk pa inserted for IC cycles, replay hits.
    wk_mode = WK_OK; wk_ack_dly = 3; wk_rsp_dly = 1; wk_pa_cfg = 64'h2000;
    i0 = n_ins;
    issue(1, 64'hffff_ffff_ffff_fff1, 12'd1);
    wait_rsp(2, 60);
    check("ins_cycles", n_ins - i0, IC);
    check("ins_pa", ins_pa_last, 64'h2000);
    check("miss_latency", rsp_cyc - grant_cyc, 9 + IC);

    // Both ports valid: grants alternate 0,1,0,1.
    tlb_add(64'hA0, 12'd2, 64'hA000);
    tlb_add(64'hB0, 12'd3, 64'hB000);
    r0 = n_rsp; g0 = n_grants; gs = grant_log.size();
    @(posedge clk); #1;
    req_va = {64'hB0, 64'hA0}; req_pcid = {12'd3, 12'd2}; req_valid = 2'b11;
    for (int k = 0; k < 100 && n_grants < g0 + 4; k++) @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(r0 + 4, 40);
    for (int k = 0; k < 4; k++) check("rr_order", grant_log[gs + k], k % 2);
    check("rr_sb_empty", sb_q.size(), 0);

    // TLB gives neither hit nor miss: controller waits.
    tlb_add(64'hC0, 12'd4, 64'hC000);
    tlb_quiet = 1'b1;
    r0 = n_rsp;
    issue(0, 64'hC0, 12'd4);
    repeat (4) @(posedge clk);
    check("stall_no_rsp", n_rsp, r0);
    #1 tlb_quiet = 1'b0;
    wait_rsp(r0 + 1, 20);

    // Walk fault: faulted response, no insert.
    wk_mode = WK_FAULT; wk_ack_dly = 1; wk_rsp_dly = 2;
    i0 = n_ins; r0 = n_rsp;
    issue(0, 64'h3000, 12'd5);
    wait_rsp(r0 + 1, 60);
    check("fault_no_insert", n_ins - i0, 0);

    // Walker silent: timeout fault after TO cycles in WALK_WAIT.
    wk_mode = WK_NORESP; wk_ack_dly = 0;
    r0 = n_rsp;
    issue(1, 64'hD000, 12'd6);
    wait_rsp(r0 + 1, TO + 40);
    check("timeout_latency", rsp_cyc - ack_cyc, TO + 1);

    // Response on the final timeout cycle wins.
    wk_mode = WK_OK; wk_ack_dly = 0; wk_rsp_dly = TO - 1; wk_pa_cfg = 64'h4000;
    i0 = n_ins; r0 = n_rsp;
    issue(0, 64'h5000, 12'd7);
    wait_rsp(r0 + 1, TO + 40);
    check("late_walk_latency", rsp_cyc - ack_cyc, TO + IC + 2);
    check("late_walk_ins", n_ins - i0, IC);

    // Flush raised during WALK_WAIT is deferred until after the response.
    wk_mode = WK_OK; wk_ack_dly = 0; wk_rsp_dly = 5; wk_pa_cfg = 64'h6000;
    f0 = n_flush; r0 = n_rsp; w0 = n_ack;
    issue(0, 64'h7000, 12'd8);
    for (int k = 0; k < 40 && n_ack == w0; k++) @(posedge clk);
    #1 flush_req = 1'b1;
    wait_rsp(r0 + 1, 60);
    for (int k = 0; k < 20 && n_flush == f0; k++) @(posedge clk);
    #1 flush_req = 1'b0;
    check("flush_count", n_flush - f0, 1);
    check("flush_after_rsp", shut_cyc - rsp_cyc, 2);

    // Flush and request together in IDLE: flush first.
    tlb_add(64'h1111, 12'd9, 64'h2222);
    f0 = n_flush; g0 = n_grants; r0 = n_rsp;
    @(posedge clk); #1;
    flush_req = 1'b1;
    req_va[2*VA_W-1:VA_W] = 64'h1111; req_pcid[2*PCID_W-1:PCID_W] = 12'd9; req_valid[1] = 1'b1;
    for (int k = 0; k < 20 && n_flush == f0; k++) @(posedge clk);
    check("flush_first", n_grants - g0, 0);
    #1 flush_req = 1'b0;
    for (int k = 0; k < 20 && n_grants == g0; k++) @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(r0 + 1, 20);
    check("flush_before_grant", grant_cyc - shut_cyc, 1);

    // Reset during INSERT: outputs drop at once, the transaction is abandoned.
    wk_mode = WK_OK; wk_ack_dly = 0; wk_rsp_dly = 0; wk_pa_cfg = 64'h8000;
    issue(0, 64'h9000, 12'd10);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = tlb_insert;
    end
    check("saw_insert", seen, 1);
    #2 shutdown_n = 1'b0;
    #1 check("rst_async_outs", any_out, 0);
    repeat (2) @(posedge clk);
    #3 shutdown_n = 1'b1;
    r0 = n_rsp;
    @(posedge clk); #1;
    t_rsp = 1'b1; t_pa = 64'hdead;
    @(posedge clk); #1;
    t_rsp = 1'b0; t_pa = '0;
    repeat (10) @(posedge clk);
    check("stale_no_rsp", n_rsp, r0);
    check("stale_sb_empty", sb_q.size(), 0);

    // Controller still serves requests after the abandoned transaction.
    issue(1, 64'h9000, 12'd10);
    wait_rsp(r0 + 1, 60);
    check("final_sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
